// File: rtl/mp_pkg.sv
// Shared types and default sizing for the master-port serial transmitter.
// No logic of its own; all consumers import mp_pkg::*.
// Holds the FSM state type and a constant helper for width selection.
package mp_pkg;

  localparam int DEF_SLV_W  = 2;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACK_TO = 8;

  typedef enum logic [3:0] {
    IDLE, REQ, SLV, ACKW, SPLIT, ADDR, DATA, RDATA, WAITS, DONE
  } mp_state_t;

  // Largest of three values; used to size shared counters and shifters.
  function automatic int mp_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, LSB-first shift register with a count of bits already shifted.
// Latency: loaded bit 0 appears on bit_dat the cycle after load; one bit per shift.
// No backpressure: the owner decides each cycle whether to load, shift or clear.
module piso_shift #(
  parameter int W     = 12,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             shift,
  input  logic             clr,
  input  logic [W-1:0]     din,
  output logic             bit_dat,
  output logic [CNT_W-1:0] cnt
);

  logic [W-1:0] sreg;

  // bit_dat is itself a flop so the serial output stays registered
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      sreg    <= '0;
      bit_dat <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      bit_dat <= din[0];
      sreg    <= din >> 1;
      cnt     <= '0;
    end else if (shift) begin
      bit_dat <= sreg[0];
      sreg    <= sreg >> 1;
      cnt     <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/master_port_tx.sv
// Bus master port: arbitrates, serialises slave ID/address/data, collects read data.
// Latency: 1 cycle IDLE->REQ, then grant wait, SLV_W+ack+ADDR_W+DATA_W(or read)+ready cycles.
// Stalls in REQ on grant, ACKW on decoder ack, SPLIT on busy slave, RDATA on valid, WAITS on ready.
module master_port_tx
  import mp_pkg::*;
#(
  parameter int SLV_W  = DEF_SLV_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACK_TO = DEF_ACK_TO
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              M_START,
  input  logic              M_WRITE,
  input  logic [SLV_W-1:0]  M_SLAVE,
  input  logic [ADDR_W-1:0] M_ADDR,
  input  logic [DATA_W-1:0] M_WDATA,
  output logic              M_READY,
  output logic              M_DONE,
  output logic              M_ERR,
  output logic [DATA_W-1:0] M_RDATA,
  output logic              M_BREQ,
  input  logic              M_BGRANT,
  output logic              B_BUS_OUT,
  output logic              B_UTIL,
  output logic              A_ADD,
  output logic              B_MODE,
  input  logic              AD_ACK,
  input  logic              S_SPLIT,
  input  logic              S_READY,
  input  logic              S_RVALID,
  input  logic              B_BUS_IN
);

  localparam int PW    = mp_max3(SLV_W, ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(mp_max3(ADDR_W, DATA_W, ACK_TO)) + 1;
  localparam logic [CNT_W-1:0] SLV_LAST  = CNT_W'(SLV_W - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TO - 1);

  mp_state_t         state;
  logic              wr_q;
  logic [SLV_W-1:0]  slv_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsh;
  logic [DATA_W-1:0] rd_next;
  logic [CNT_W-1:0]  cnt;

  logic              sh_load, sh_shift, sh_clr;
  logic [PW-1:0]     sh_din;
  logic [CNT_W-1:0]  sh_cnt;

  assign rd_next = {B_BUS_IN, rsh[DATA_W-1:1]};

  // Steer the serialiser: load on entry to each serial field, shift within it, clear otherwise
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_clr   = 1'b0;
    sh_din   = '0;
    case (state)
      REQ:  if (M_BGRANT) begin sh_load = 1'b1; sh_din = PW'(slv_q); end
      SLV:  if (sh_cnt == SLV_LAST) sh_clr = 1'b1; else sh_shift = 1'b1;
      ACKW: if (AD_ACK) begin sh_load = 1'b1; sh_din = PW'(addr_q); end
      ADDR: begin
        if (sh_cnt == ADDR_LAST) begin
          if (wr_q) begin sh_load = 1'b1; sh_din = PW'(wdata_q); end
          else sh_clr = 1'b1;
        end else sh_shift = 1'b1;
      end
      DATA: if (sh_cnt == DATA_LAST) sh_clr = 1'b1; else sh_shift = 1'b1;
      default: sh_clr = 1'b1;
    endcase
  end

  piso_shift #(.W(PW), .CNT_W(CNT_W)) u_piso (
    .CLK     (CLK),
    .RST     (RST),
    .load    (sh_load),
    .shift   (sh_shift),
    .clr     (sh_clr),
    .din     (sh_din),
    .bit_dat (B_BUS_OUT),
    .cnt     (sh_cnt)
  );

  // Transfer FSM; every output is set on the edge that enters the state it belongs to
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      M_READY <= 1'b1;
      M_DONE  <= 1'b0;
      M_ERR   <= 1'b0;
      M_RDATA <= '0;
      M_BREQ  <= 1'b0;
      B_UTIL  <= 1'b0;
      A_ADD   <= 1'b0;
      B_MODE  <= 1'b0;
      wr_q    <= 1'b0;
      slv_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsh     <= '0;
      cnt     <= '0;
    end else begin
      M_DONE <= 1'b0;
      M_ERR  <= 1'b0;
      case (state)
        IDLE: if (M_START) begin
          wr_q    <= M_WRITE;
          slv_q   <= M_SLAVE;
          addr_q  <= M_ADDR;
          wdata_q <= M_WDATA;
          cnt     <= '0;
          M_READY <= 1'b0;
          M_BREQ  <= 1'b1;
          state   <= REQ;
        end
        REQ: if (M_BGRANT) begin
          B_UTIL <= 1'b1;
          A_ADD  <= 1'b1;
          B_MODE <= wr_q;
          state  <= SLV;
        end
        SLV: if (sh_cnt == SLV_LAST) begin
          // A_ADD stays high through ACKW so the decoder keeps its selection
          B_UTIL <= 1'b0;
          cnt    <= '0;
          state  <= ACKW;
        end
        ACKW: begin
          if (AD_ACK) begin
            B_UTIL <= 1'b1;
            A_ADD  <= 1'b0;
            state  <= ADDR;
          end else if (S_SPLIT) begin
            M_BREQ <= 1'b0;
            A_ADD  <= 1'b0;
            state  <= SPLIT;
          end else if (cnt == ACK_LAST) begin
            M_DONE <= 1'b1;
            M_ERR  <= 1'b1;
            M_BREQ <= 1'b0;
            A_ADD  <= 1'b0;
            B_MODE <= 1'b0;
            cnt    <= '0;
            state  <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SPLIT: if (!S_SPLIT) begin
          // retry restarts arbitration and resends the whole slave ID
          M_BREQ <= 1'b1;
          B_MODE <= 1'b0;
          state  <= REQ;
        end
        ADDR: if (sh_cnt == ADDR_LAST) begin
          cnt <= '0;
          if (wr_q) begin
            state <= DATA;
          end else begin
            B_UTIL <= 1'b0;
            state  <= RDATA;
          end
        end
        DATA: if (sh_cnt == DATA_LAST) begin
          B_UTIL <= 1'b0;
          state  <= WAITS;
        end
        RDATA: if (S_RVALID) begin
          rsh <= rd_next;
          if (cnt == DATA_LAST) begin
            M_RDATA <= rd_next;
            cnt     <= '0;
            state   <= WAITS;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAITS: if (S_READY) begin
          M_DONE <= 1'b1;
          M_BREQ <= 1'b0;
          B_MODE <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          M_READY <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_port_tx.sv
// Directed bench: builds an expected per-cycle waveform from transfer descriptions,
// replays the matching input schedule, and compares every output every cycle.
module tb_master_port_tx;

  typedef struct packed {
    logic        rst, start, write;
    logic [1:0]  slave;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        bgrant, adack, split, sready, rvalid, bin;
  } in_t;

  typedef struct packed {
    logic       ready, done, err, breq, bus, util, aadd, mode;
    logic [7:0] rdata;
  } out_t;

  logic        CLK;
  logic        RST, M_START, M_WRITE, M_BGRANT, AD_ACK, S_SPLIT, S_READY, S_RVALID, B_BUS_IN;
  logic [1:0]  M_SLAVE;
  logic [11:0] M_ADDR;
  logic [7:0]  M_WDATA, M_RDATA;
  logic        M_READY, M_DONE, M_ERR, M_BREQ, B_BUS_OUT, B_UTIL, A_ADD, B_MODE;

  master_port_tx dut (
    .CLK(CLK), .RST(RST), .M_START(M_START), .M_WRITE(M_WRITE), .M_SLAVE(M_SLAVE),
    .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_READY(M_READY), .M_DONE(M_DONE), .M_ERR(M_ERR),
    .M_RDATA(M_RDATA), .M_BREQ(M_BREQ), .M_BGRANT(M_BGRANT), .B_BUS_OUT(B_BUS_OUT),
    .B_UTIL(B_UTIL), .A_ADD(A_ADD), .B_MODE(B_MODE), .AD_ACK(AD_ACK), .S_SPLIT(S_SPLIT),
    .S_READY(S_READY), .S_RVALID(S_RVALID), .B_BUS_IN(B_BUS_IN)
  );

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  in_t  inq[$];
  out_t outq[$];
  bit   chkq[$];

  logic [7:0] rdata_m = 8'h00;
  bit         noise = 0;
  in_t        noise_in;

  int errors = 0;
  int checks = 0;

  function automatic out_t o_of(input logic ready, done, err, breq, bus, util, aadd, mode);
    out_t o;
    o = {ready, done, err, breq, bus, util, aadd, mode, rdata_m};
    return o;
  endfunction

  // Non-IDLE cycles optionally carry a stray M_START with different fields
  function automatic in_t base_in();
    in_t i;
    i = '0;
    if (noise) i = noise_in;
    return i;
  endfunction

  task automatic push(input in_t i, input out_t o, input bit chk);
    inq.push_back(i);
    outq.push_back(o);
    chkq.push_back(chk);
  endtask

  // One transfer expressed as its cycle-by-cycle waveform
  task automatic add_txn(input logic wr, input logic [1:0] slv, input logic [11:0] addr,
                         input logic [7:0] wd, input int gw, input int aw, input int split_len,
                         input bit tmo, input bit both, input logic [7:0] rd,
                         input logic [31:0] gaps, input int ws, input int rst_bit, input bit nz);
    in_t i;
    int  g, wait_g, wait_a, pend_split;
    bit  retry;
    i = '0; i.start = 1; i.write = wr; i.slave = slv; i.addr = addr; i.wdata = wd;
    push(i, o_of(1, 0, 0, 0, 0, 0, 0, 0), 1);
    noise = nz;
    noise_in = '0; noise_in.start = 1; noise_in.write = ~wr; noise_in.slave = ~slv;
    noise_in.addr = ~addr; noise_in.wdata = ~wd;
    wait_g = gw; wait_a = aw; pend_split = split_len;
    do begin
      for (int c = 0; c < wait_g; c++) push(base_in(), o_of(0, 0, 0, 1, 0, 0, 0, 0), 1);
      i = base_in(); i.bgrant = 1;
      push(i, o_of(0, 0, 0, 1, 0, 0, 0, 0), 1);
      for (int b = 0; b < 2; b++) push(base_in(), o_of(0, 0, 0, 1, slv[b], 1, 1, wr), 1);
      for (int c = 0; c < wait_a; c++) push(base_in(), o_of(0, 0, 0, 1, 0, 0, 1, wr), 1);
      retry = 0;
      if (pend_split > 0) begin
        i = base_in(); i.split = 1;
        push(i, o_of(0, 0, 0, 1, 0, 0, 1, wr), 1);
        for (int c = 1; c < pend_split; c++) push(i, o_of(0, 0, 0, 0, 0, 0, 0, wr), 1);
        push(base_in(), o_of(0, 0, 0, 0, 0, 0, 0, wr), 1);
        pend_split = 0; wait_g = 0; wait_a = 0; retry = 1;
      end
    end while (retry);
    if (tmo) begin
      for (int c = 0; c < 8; c++) push(base_in(), o_of(0, 0, 0, 1, 0, 0, 1, wr), 1);
      push(base_in(), o_of(0, 1, 1, 0, 0, 0, 0, 0), 1);
      noise = 0;
      return;
    end
    i = base_in(); i.adack = 1; i.split = both;
    push(i, o_of(0, 0, 0, 1, 0, 0, 1, wr), 1);
    for (int j = 0; j < 12; j++) begin
      i = base_in();
      if (j == rst_bit) i.rst = 1;
      push(i, o_of(0, 0, 0, 1, addr[j], 1, 0, wr), 1);
      if (j == rst_bit) begin
        rdata_m = 8'h00;
        noise = 0;
        return;
      end
    end
    if (wr) begin
      for (int j = 0; j < 8; j++) push(base_in(), o_of(0, 0, 0, 1, wd[j], 1, 0, 1), 1);
    end else begin
      for (int b = 0; b < 8; b++) begin
        g = int'(gaps[4*b +: 4]);
        for (int c = 0; c < g; c++) begin
          i = base_in(); i.bin = ~rd[b];
          push(i, o_of(0, 0, 0, 1, 0, 0, 0, 0), 1);
        end
        i = base_in(); i.rvalid = 1; i.bin = rd[b];
        push(i, o_of(0, 0, 0, 1, 0, 0, 0, 0), 1);
      end
      rdata_m = rd;
    end
    for (int c = 0; c < ws; c++) push(base_in(), o_of(0, 0, 0, 1, 0, 0, 0, wr), 1);
    i = base_in(); i.sready = 1;
    push(i, o_of(0, 0, 0, 1, 0, 0, 0, wr), 1);
    push(base_in(), o_of(0, 1, 0, 0, 0, 0, 0, 0), 1);
    noise = 0;
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  logic       bitlog[$];
  logic [7:0] done_rd[$];
  int         done_cnt = 0, err_cnt = 0, run = 0, last_run = 0, err_run = -1;

  initial begin
    in_t  i;
    out_t act;
    logic [21:0] v;

    i = '0; i.rst = 1;
    push(i, o_of(1, 0, 0, 0, 0, 0, 0, 0), 0);
    push(i, o_of(1, 0, 0, 0, 0, 0, 0, 0), 1);
    add_txn(1, 2'b10, 12'h0A5, 8'h3C, 2, 1, 0, 0, 0, 8'h00, 32'h0, 2, -1, 0);
    add_txn(0, 2'b01, 12'h123, 8'h00, 1, 0, 0, 0, 0, 8'hA7, 32'h0103_0120, 0, -1, 1);
    add_txn(1, 2'b11, 12'h5A0, 8'h81, 0, 2, 5, 0, 0, 8'h00, 32'h0, 1, -1, 0);
    add_txn(1, 2'b00, 12'h3FF, 8'hFF, 0, 0, 0, 1, 0, 8'h00, 32'h0, 0, -1, 0);
    add_txn(1, 2'b01, 12'h9F6, 8'h55, 1, 0, 0, 0, 0, 8'h00, 32'h0, 0, 3, 0);
    add_txn(0, 2'b10, 12'h001, 8'h00, 0, 0, 0, 0, 1, 8'h5E, 32'h0000_0002, 1, -1, 1);
    for (int c = 0; c < 3; c++) push('0, o_of(1, 0, 0, 0, 0, 0, 0, 0), 1);

    for (int k = 0; k < inq.size(); k++) begin
      i = inq[k];
      RST = i.rst; M_START = i.start; M_WRITE = i.write; M_SLAVE = i.slave;
      M_ADDR = i.addr; M_WDATA = i.wdata; M_BGRANT = i.bgrant; AD_ACK = i.adack;
      S_SPLIT = i.split; S_READY = i.sready; S_RVALID = i.rvalid; B_BUS_IN = i.bin;
      @(negedge CLK);
      act = {M_READY, M_DONE, M_ERR, M_BREQ, B_BUS_OUT, B_UTIL, A_ADD, B_MODE, M_RDATA};
      if (chkq[k]) begin
        checks++;
        if (act !== outq[k]) begin
          errors++;
          $display("FAIL cycle%0d outputs {rdy,done,err,breq,bus,util,aadd,mode,rdata}: got %b want %b",
                   k, act, outq[k]);
        end
        if (B_UTIL === 1'b1) bitlog.push_back(B_BUS_OUT);
        if (A_ADD === 1'b1 && B_UTIL === 1'b0) run++;
        else if (run > 0) begin last_run = run; run = 0; end
        if (M_DONE === 1'b1) begin
          done_cnt++;
          done_rd.push_back(M_RDATA);
          if (M_ERR === 1'b1) begin err_cnt++; err_run = last_run; end
        end
      end
      @(posedge CLK);
      #1;
    end

    v = '0;
    for (int b = 0; b < 22; b++) if (b < bitlog.size()) v[b] = bitlog[b];
    check_lit("first_write_serial_stream", 32'(v), 32'({8'h3C, 12'h0A5, 2'b10}));
    check_lit("done_pulses", 32'(done_cnt), 32'd5);
    check_lit("err_pulses", 32'(err_cnt), 32'd1);
    check_lit("ackw_cycles_before_timeout", 32'(err_run), 32'd8);
    check_lit("read_data_0xA7", (done_rd.size() > 1) ? 32'(done_rd[1]) : 32'hDEAD, 32'h0000_00A7);
    check_lit("read_data_0x5E", (done_rd.size() > 4) ? 32'(done_rd[4]) : 32'hDEAD, 32'h0000_005E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
